// File: rtl/lpc_decoder_pkg.sv
// Shared definitions for the LPC snooper: FSM states, cycle-type codes,
// SYNC nibble codes and a helper for the address length.
package lpc_defs;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CYCTYPE = 3'd1,
    ADDR    = 3'd2,
    DATA    = 3'd3,
    TAR1    = 3'd4,
    SYNC    = 3'd5,
    TAR2    = 3'd6
  } state_e;

  // Cycle type lives in cyctype/dir nibble bits [3:2]
  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;

  // Direction bit inside the cyctype/dir nibble (1 = write)
  localparam int DIR_BIT = 1;

  // SYNC nibble codes
  localparam logic [3:0] READY      = 4'h0;
  localparam logic [3:0] SHORT_WAIT = 4'h5;
  localparam logic [3:0] LONG_WAIT  = 4'h6;
  localparam logic [3:0] ERROR      = 4'hA;

  // Index of the last address nibble: I/O carries 4 nibbles, memory 8
  function automatic logic [2:0] last_addr_nibble(input logic [1:0] ctype);
    return (ctype == CT_IO) ? 3'd3 : 3'd7;
  endfunction

endpackage

// File: rtl/lpc_decoder_if.sv
// Bundle of LPC bus inputs and decoded-cycle outputs of the snooper.
// master: the bus side (drives LFRAME#/LAD, observes decoded results).
// slave:  the decoder itself.
interface lpc_decoder_if;
  logic        lpc_frame;
  logic [3:0]  lpc_ad;
  logic [3:0]  lpc_cyctype_dir;
  logic [31:0] lpc_addr;
  logic [7:0]  lpc_data;
  logic        lpc_latch;
  logic        lpc_busy;

  modport master (
    output lpc_frame, lpc_ad,
    input  lpc_cyctype_dir, lpc_addr, lpc_data, lpc_latch, lpc_busy
  );

  modport slave (
    input  lpc_frame, lpc_ad,
    output lpc_cyctype_dir, lpc_addr, lpc_data, lpc_latch, lpc_busy
  );
endinterface

// File: rtl/lpc_decoder.sv
// Passive LPC bus snooper. Decodes I/O and memory read/write cycles from
// LFRAME#/LAD and, for every completed cycle, presents type/dir, address
// and data with a one-clock lpc_latch pulse. Never drives the bus.
module lpc_decoder
  import lpc_defs::*;
#(
  parameter int SYNC_TIMEOUT = 8
) (
  input  logic          clock,
  input  logic          reset,
  lpc_decoder_if.slave  bus
);

  localparam logic [7:0] WAIT_LAST = 8'(SYNC_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;        // nibble counter within ADDR/DATA/TAR
  logic [7:0]  wait_q, wait_d;      // consecutive SYNC wait nibbles
  logic [3:0]  ct_q, ct_d;          // shadow cyctype/dir nibble
  logic [31:0] addr_q, addr_d;      // shadow address
  logic [7:0]  data_q, data_d;      // shadow data
  logic [3:0]  out_ct_q, out_ct_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        latch_q, latch_d;

  logic is_write;
  assign is_write = ct_q[DIR_BIT];

  // Next-state, shadow capture and latch generation
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    ct_d       = ct_q;
    addr_d     = addr_q;
    data_d     = data_q;
    out_ct_d   = out_ct_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    latch_d    = 1'b0;

    if (!bus.lpc_frame) begin
      // START (LAD=0) restarts decoding from any state; anything else aborts
      state_d = (bus.lpc_ad == 4'h0) ? CYCTYPE : IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CYCTYPE: begin
          ct_d   = bus.lpc_ad;
          addr_d = '0;
          cnt_d  = '0;
          // Type 1x (DMA/reserved) is not decoded
          state_d = bus.lpc_ad[3] ? IDLE : ADDR;
        end
        ADDR: begin
          addr_d = {addr_q[27:0], bus.lpc_ad};
          if (cnt_q == last_addr_nibble(ct_q[3:2])) begin
            cnt_d   = '0;
            state_d = is_write ? DATA : TAR1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        DATA: begin
          if (cnt_q == 3'd0) begin
            data_d[3:0] = bus.lpc_ad;
            cnt_d       = 3'd1;
          end else begin
            data_d[7:4] = bus.lpc_ad;
            cnt_d       = '0;
            state_d     = is_write ? TAR1 : TAR2;
          end
        end
        TAR1: begin
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            cnt_d   = '0;
            wait_d  = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          unique case (bus.lpc_ad)
            READY: begin
              cnt_d   = '0;
              state_d = is_write ? TAR2 : DATA;
            end
            SHORT_WAIT, LONG_WAIT: begin
              wait_d = wait_q + 8'd1;
              if (wait_q == WAIT_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;   // ERROR or unknown code
          endcase
        end
        TAR2: begin
          if (cnt_q == 3'd0) begin
            cnt_d = 3'd1;
          end else begin
            // Only completed cycles reach TAR2, so publish the shadow copy
            cnt_d      = '0;
            state_d    = IDLE;
            latch_d    = 1'b1;
            out_ct_d   = ct_q;
            out_addr_d = addr_q;
            out_data_d = data_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      ct_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      out_ct_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      latch_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      ct_q       <= ct_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      out_ct_q   <= out_ct_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      latch_q    <= latch_d;
    end
  end

  assign bus.lpc_cyctype_dir = out_ct_q;
  assign bus.lpc_addr        = out_addr_q;
  assign bus.lpc_data        = out_data_q;
  assign bus.lpc_latch       = latch_q;
  assign bus.lpc_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lpc_decoder.sv
// Self-checking bench for lpc_decoder. Stimulus is built as a list of LPC
// nibbles, each annotated with what the decoder must show after sampling
// it (busy, latch, published values), derived from the protocol rules.
module tb_lpc_decoder;

  localparam int SYNC_TIMEOUT = 8;

  typedef struct {
    logic        frame;
    logic [3:0]  ad;
    logic        busy;
    logic        latch;
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [7:0]  data;
  } nib_t;

  typedef struct {
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [7:0]  data;
  } rec_t;

  logic clock;
  logic reset;

  lpc_decoder_if bus ();

  lpc_decoder #(.SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  nib_t stim[$];
  rec_t seen[$];

  // Expected DUT view after the next sampling edge
  logic        chk_en   = 1'b0;
  logic        exp_busy = 1'b0;
  logic        exp_latch = 1'b0;
  logic [3:0]  mdl_ct   = '0;
  logic [31:0] mdl_addr = '0;
  logic [7:0]  mdl_data = '0;

  // Abort injection for the cycle under construction
  int   abort_at = -1;
  int   nib_idx  = 0;
  logic aborted  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input logic frame, input logic [3:0] ad, input logic busy,
                      input logic latch = 1'b0, input logic [3:0] ct = '0,
                      input logic [31:0] addr = '0, input logic [7:0] data = '0);
    nib_t e;
    if (aborted) return;
    if (abort_at > 0 && nib_idx == abort_at) begin
      e = '{frame: 1'b0, ad: 4'($urandom_range(1, 15)), busy: 1'b0, latch: 1'b0,
            ct: '0, addr: '0, data: '0};
      stim.push_back(e);
      aborted = 1'b1;
      return;
    end
    e = '{frame: frame, ad: ad, busy: busy, latch: latch, ct: ct, addr: addr, data: data};
    stim.push_back(e);
    nib_idx++;
  endtask

  task automatic idle_nibbles(input int n);
    for (int i = 0; i < n; i++) push(1'b1, rnd4(), 1'b0);
  endtask

  // One LPC I/O or memory cycle. wait_code 0 picks 5/6 at random per wait.
  task automatic add_cycle(input logic [1:0] ctype, input logic wr, input logic ct_lsb,
                           input logic [31:0] addr, input logic [7:0] data,
                           input int waits, input logic [3:0] wait_code,
                           input logic [3:0] final_sync);
    logic [3:0]  ct;
    logic [31:0] a;
    logic [3:0]  code;
    int          n;
    nib_idx = 0;
    aborted = 1'b0;
    ct = {ctype, wr, ct_lsb};
    n  = (ctype == 2'b01) ? 8 : 4;
    a  = (n == 4) ? {16'h0000, addr[15:0]} : addr;
    push(1'b0, 4'h0, 1'b1);
    push(1'b1, ct, 1'b1);
    for (int i = 0; i < n; i++) push(1'b1, a[4*(n-1-i) +: 4], 1'b1);
    if (wr) begin
      push(1'b1, data[3:0], 1'b1);
      push(1'b1, data[7:4], 1'b1);
    end
    push(1'b1, rnd4(), 1'b1);
    push(1'b1, rnd4(), 1'b1);
    for (int w = 1; w <= waits; w++) begin
      code = (wait_code != 4'h0) ? wait_code : (($urandom_range(0, 1) == 0) ? 4'h5 : 4'h6);
      push(1'b1, code, (w < SYNC_TIMEOUT));
    end
    if (waits >= SYNC_TIMEOUT) return;
    push(1'b1, final_sync, (final_sync == 4'h0));
    if (final_sync != 4'h0) return;
    if (!wr) begin
      push(1'b1, data[3:0], 1'b1);
      push(1'b1, data[7:4], 1'b1);
    end
    push(1'b1, rnd4(), 1'b1);
    push(1'b1, rnd4(), 1'b0, 1'b1, ct, a, data);
  endtask

  // Apply queued nibbles, one per clock, on the falling edge
  task automatic run_stim();
    nib_t e;
    while (stim.size() > 0) begin
      e = stim.pop_front();
      @(negedge clock);
      bus.lpc_frame = e.frame;
      bus.lpc_ad    = e.ad;
      exp_busy      = e.busy;
      exp_latch     = e.latch;
      if (e.latch) begin
        mdl_ct   = e.ct;
        mdl_addr = e.addr;
        mdl_data = e.data;
      end
    end
  endtask

  task automatic check_rec(input int idx, input logic [3:0] ct, input logic [31:0] addr,
                           input logic [7:0] data);
    if (idx < seen.size()) begin
      check($sformatf("rec%0d_ct", idx),   32'(seen[idx].ct),   32'(ct));
      check($sformatf("rec%0d_addr", idx), seen[idx].addr,     addr);
      check($sformatf("rec%0d_data", idx), 32'(seen[idx].data), 32'(data));
    end else begin
      check($sformatf("rec%0d_missing", idx), 32'(seen.size()), 32'(idx + 1));
    end
  endtask

  // Compare process: every clock, DUT outputs against the expected view
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (chk_en) begin
        check("latch", 32'(bus.lpc_latch), 32'(exp_latch));
        check("busy",  32'(bus.lpc_busy),  32'(exp_busy));
        check("cyctype_dir", 32'(bus.lpc_cyctype_dir), 32'(mdl_ct));
        check("addr",  bus.lpc_addr, mdl_addr);
        check("data",  32'(bus.lpc_data), 32'(mdl_data));
        if (bus.lpc_latch === 1'b1)
          seen.push_back('{ct: bus.lpc_cyctype_dir, addr: bus.lpc_addr, data: bus.lpc_data});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [3:0] err;
    int         kind;
    int         waits;

    reset         = 1'b0;
    bus.lpc_frame = 1'b1;
    bus.lpc_ad    = 4'h0;
    #12;
    check("rst_latch", 32'(bus.lpc_latch), 32'h0);
    check("rst_busy",  32'(bus.lpc_busy),  32'h0);
    check("rst_ct",    32'(bus.lpc_cyctype_dir), 32'h0);
    check("rst_addr",  bus.lpc_addr, 32'h0);
    check("rst_data",  32'(bus.lpc_data), 32'h0);
    @(negedge clock);
    reset  = 1'b1;
    chk_en = 1'b1;

    // Directed cycles
    idle_nibbles(2);
    add_cycle(2'b00, 1'b1, 1'b0, 32'h0000_0080, 8'h5A, 0, 4'h0, 4'h0);
    idle_nibbles(2);
    add_cycle(2'b01, 1'b0, 1'b0, 32'hFFFF_FFF0, 8'h3C, 3, 4'h5, 4'h0);
    idle_nibbles(1);
    add_cycle(2'b01, 1'b0, 1'b0, 32'hDEAD_BEEF, 8'h77, 9, 4'h6, 4'h0);
    idle_nibbles(2);
    add_cycle(2'b01, 1'b1, 1'b0, 32'h1234_5678, 8'hA5, SYNC_TIMEOUT - 1, 4'h0, 4'h0);
    abort_at = 4;
    add_cycle(2'b00, 1'b0, 1'b0, 32'h0000_9999, 8'hEE, 0, 4'h0, 4'h0);
    abort_at = -1;
    add_cycle(2'b00, 1'b0, 1'b0, 32'h0000_0060, 8'h11, 0, 4'h0, 4'h0);
    idle_nibbles(1);
    push(1'b0, 4'h0, 1'b1);
    push(1'b1, 4'h8, 1'b0);
    idle_nibbles(3);
    add_cycle(2'b00, 1'b1, 1'b0, 32'h0000_0070, 8'h42, 1, 4'h5, 4'hA);
    idle_nibbles(2);
    run_stim();
    @(posedge clock);
    #2;
    check("directed_latches", 32'(seen.size()), 32'd4);
    check_rec(0, 4'h2, 32'h0000_0080, 8'h5A);
    check_rec(1, 4'h4, 32'hFFFF_FFF0, 8'h3C);
    check_rec(2, 4'h6, 32'h1234_5678, 8'hA5);
    check_rec(3, 4'h0, 32'h0000_0060, 8'h11);
    seen.delete();

    // Reset in the middle of a memory write's DATA phase
    push(1'b0, 4'h0, 1'b1);
    push(1'b1, 4'h6, 1'b1);
    for (int i = 0; i < 8; i++) push(1'b1, rnd4(), 1'b1);
    push(1'b1, 4'h9, 1'b1);
    run_stim();
    @(posedge clock);
    #2;
    chk_en = 1'b0;
    bus.lpc_frame = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("midrst_latch", 32'(bus.lpc_latch), 32'h0);
    check("midrst_busy",  32'(bus.lpc_busy),  32'h0);
    check("midrst_ct",    32'(bus.lpc_cyctype_dir), 32'h0);
    check("midrst_addr",  bus.lpc_addr, 32'h0);
    check("midrst_data",  32'(bus.lpc_data), 32'h0);
    repeat (2) @(negedge clock);
    reset     = 1'b1;
    exp_busy  = 1'b0;
    exp_latch = 1'b0;
    mdl_ct    = '0;
    mdl_addr  = '0;
    mdl_data  = '0;
    chk_en    = 1'b1;
    add_cycle(2'b00, 1'b1, 1'b0, 32'h0000_03F8, 8'hC3, 0, 4'h0, 4'h0);
    idle_nibbles(2);
    run_stim();
    @(posedge clock);
    #2;
    check("post_reset_latches", 32'(seen.size()), 32'd1);
    check_rec(0, 4'h2, 32'h0000_03F8, 8'hC3);

    // Randomized traffic
    for (int c = 0; c < 160; c++) begin
      kind  = $urandom_range(0, 9);
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(SYNC_TIMEOUT - 1, SYNC_TIMEOUT + 1)
                                         : $urandom_range(0, 3);
      idle_nibbles($urandom_range(0, 2));
      case (kind)
        6: begin
          push(1'b0, 4'h0, 1'b1);
          push(1'b1, {1'b1, 3'($urandom_range(0, 7))}, 1'b0);
          idle_nibbles($urandom_range(0, 3));
        end
        7: begin
          do err = rnd4(); while (err == 4'h0 || err == 4'h5 || err == 4'h6);
          add_cycle(2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, 8'($urandom), $urandom_range(0, 2), 4'h0, err);
        end
        8: begin
          abort_at = $urandom_range(1, 20);
          add_cycle(2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, 8'($urandom), waits, 4'h0, 4'h0);
          abort_at = -1;
        end
        default: begin
          if (kind == 9) push(1'b0, 4'($urandom_range(1, 15)), 1'b0);
          add_cycle(2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, 8'($urandom), waits, 4'h0, 4'h0);
        end
      endcase
    end
    idle_nibbles(3);
    run_stim();
    @(posedge clock);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
